bin2sseg_fmt: RTL and testbench
===============================

// Module: bin2sseg_fmt
// PURPOSE
// Converts a 14-bit binary value (0..9999) to four 8-bit seven-segment patterns
// using a sequential double-dabble (shift-add-3) engine, one bit per cycle.
// Sits directly upstream of the 4-digit time-multiplexed display driver and
// feeds its in3..in0 inputs. Outputs are registered and hold between conversions.
// PARAMETERS
// ACTIVE_LOW  1  1: segment/dp bits are active-low (common anode); 0: invert all led* patterns
// PORTS
// clk        in   1   system clock
// reset      in   1   asynchronous, active-high reset
// start      in   1   request conversion; accepted only while ready=1
// bin        in   14  binary value; captured on accepted start
// blank_lz   in   1   1: blank leading zeros; captured on accepted start
// dp_en      in   1   1: light the decimal point on digit dp_pos; captured on start
// dp_pos     in   2   digit index 0..3 (0 = led0, rightmost) for the decimal point
// ready      out  1   1 in IDLE; start is ignored when 0
// done_tick  out  1   one-cycle pulse; led3..led0 and overflow are valid from this cycle
// overflow   out  1   1: last captured bin > 9999
// led3..led0 out  8   bit7 = dp, bits6:0 = g f e d c b a; led3 = most-significant digit
// BEHAVIOUR
// - Reset (any time, incl. mid-conversion): state IDLE, ready=1, done_tick=0,
//   overflow=0, led3..led0 = 8'hFF (all off). Any conversion in progress is lost.
// - FSM IDLE -> OP -> DONE -> IDLE. ready = (state==IDLE); done_tick = (state==DONE).
// - IDLE: start=1 -> capture bin/blank_lz/dp_en/dp_pos, clear 16-bit BCD reg, n=13.
//   If bin > 9999 -> DONE directly; overflow=1, all led = 8'hBF ('-'), no dp.
//   Else -> OP; overflow=0.
// - OP: each cycle, every BCD nibble > 4 gets +3, then {bcd,shift} shifts left 1,
//   bringing in the current bin MSB. n decrements. On n==0: latch encoded
//   outputs from the final BCD value, go DONE. Exactly 14 cycles in OP.
// - DONE: one cycle, then IDLE. start sampled in DONE or OP is ignored (no queueing).
// - Latency: start high in cycle 0 -> done_tick in cycle 15, ready again in cycle 16.
//   Overflow path: done_tick in cycle 1.
// - Digit codes (ACTIVE_LOW=1, dp off): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8
//   8=80 9=90; blank=FF; dash=BF. dp on clears bit7 (e.g. '0.'=40).
// - Leading-zero blanking (blank_lz=1): scan led3 -> led1; a zero digit is blanked
//   (FF) while all digits to its left are blanked. Scan stops at the first non-zero
//   digit or the digit carrying an enabled dp. led0 is never blanked.
// - dp applies only when dp_en=1 and overflow=0. Exactly one digit carries dp.
// - ACTIVE_LOW=0: every led bit is the bitwise inverse of the table above,
//   including reset value (8'h00).
// - led outputs change only on the edge entering DONE, or on reset; they are
//   stable at all other times.
// TESTING
// 1 reset asserted -> led3..0=FF FF FF FF, ready=1, done_tick=0, overflow=0
// 2 bin=1234, blank_lz=0, dp_en=0 -> done_tick exactly in cycle 15; led=F9 A4 B0 99
// 3 bin=7, blank_lz=1 -> led=FF FF FF F8; bin=0, blank_lz=1 -> FF FF FF C0
// 4 bin=5, blank_lz=1, dp_en=1, dp_pos=2 -> led=FF 40 C0 92 ("0.05")
// 5 bin=10000 -> overflow=1, led=BF BF BF BF, done_tick in cycle 1; bin=9999 -> 90 90 90 90, overflow=0
// 6 start pulsed again mid-OP -> ignored, single done_tick; reset in cycle 7 of a
//   conversion -> led=FF, no done_tick; next start with bin=42 -> FF FF 99 A4 (blank_lz=1)

Source files
------------

// File: rtl/bin2sseg_fmt.sv
// Sequential double-dabble binary-to-BCD converter (0..9999) with formatted
// seven-segment outputs: leading-zero blanking, decimal point and overflow dashes.
module bin2sseg_fmt #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin,
  input  logic        blank_lz,
  input  logic        dp_en,
  input  logic [1:0]  dp_pos,
  output logic        ready,
  output logic        done_tick,
  output logic        overflow,
  output logic [7:0]  led3,
  output logic [7:0]  led2,
  output logic [7:0]  led1,
  output logic [7:0]  led0
);

  localparam logic [13:0] MAX_VAL  = 14'd9999;
  localparam logic [7:0]  LED_OFF  = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0]  LED_DASH = ACTIVE_LOW ? 8'hBF : 8'h40;

  typedef enum logic [1:0] {
    IDLE,
    OP,
    DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [13:0] shift_reg;
  logic [14:0] bcd_reg;
  logic [3:0]  n_reg;
  logic        blank_reg;
  logic        dp_en_reg;
  logic [1:0]  dp_pos_reg;
  logic        overflow_reg;
  logic [7:0]  led_reg [4];

  logic [11:0] bcd_adj;
  logic [15:0] bcd_next;
  logic [3:0]  dp_here;
  logic [3:0]  blank;
  logic [7:0]  led_enc [4];

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = 7'h7F;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = (bin > MAX_VAL) ? DONE : OP;
      OP:   if (n_reg == 4'd0) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready     = (state_reg == IDLE);
    done_tick = (state_reg == DONE);
  end

  // The thousands nibble holds at most 4 before the final shift (input <= 9999),
  // so it never needs the +3 correction and its top bit stays zero.
  always_comb begin
    bcd_adj = bcd_reg[11:0];
    for (int unsigned i = 0; i < 3; i++) begin
      if (bcd_reg[4*i +: 4] > 4'd4) bcd_adj[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
    end
    bcd_next = {bcd_reg[14:12], bcd_adj, shift_reg[13]};
  end

  // Blanking scans from the most-significant digit and stops at a non-zero
  // digit or at the digit that carries the decimal point.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      dp_here[i] = dp_en_reg && (dp_pos_reg == 2'(i));
    end
    blank[3] = blank_reg && (bcd_next[15:12] == 4'd0) && !dp_here[3];
    blank[2] = blank[3]  && (bcd_next[11:8]  == 4'd0) && !dp_here[2];
    blank[1] = blank[2]  && (bcd_next[7:4]   == 4'd0) && !dp_here[1];
    blank[0] = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      led_enc[i] = blank[i] ? 8'hFF : {~dp_here[i], seg_code(bcd_next[4*i +: 4])};
      if (!ACTIVE_LOW) led_enc[i] = ~led_enc[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg    <= '0;
      bcd_reg      <= '0;
      n_reg        <= '0;
      blank_reg    <= 1'b0;
      dp_en_reg    <= 1'b0;
      dp_pos_reg   <= '0;
      overflow_reg <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) led_reg[i] <= LED_OFF;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            shift_reg  <= bin;
            bcd_reg    <= '0;
            n_reg      <= 4'd13;
            blank_reg  <= blank_lz;
            dp_en_reg  <= dp_en;
            dp_pos_reg <= dp_pos;
            if (bin > MAX_VAL) begin
              overflow_reg <= 1'b1;
              for (int unsigned i = 0; i < 4; i++) led_reg[i] <= LED_DASH;
            end else begin
              overflow_reg <= 1'b0;
            end
          end
        end
        OP: begin
          shift_reg <= {shift_reg[12:0], 1'b0};
          bcd_reg   <= bcd_next[14:0];
          n_reg     <= n_reg - 4'd1;
          if (n_reg == 4'd0) begin
            for (int unsigned i = 0; i < 4; i++) led_reg[i] <= led_enc[i];
          end
        end
        default: ;
      endcase
    end
  end

  assign overflow = overflow_reg;
  assign led3     = led_reg[3];
  assign led2     = led_reg[2];
  assign led1     = led_reg[1];
  assign led0     = led_reg[0];

endmodule

// File: tb/tb_bin2sseg_fmt.sv
// Directed self-checking bench for bin2sseg_fmt: latency, formatting, overflow,
// ignored restarts and mid-conversion reset.
module tb_bin2sseg_fmt;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] bin;
  logic        blank_lz;
  logic        dp_en;
  logic [1:0]  dp_pos;
  logic        ready;
  logic        done_tick;
  logic        overflow;
  logic [7:0]  led3, led2, led1, led0;

  int total = 0;
  int bad   = 0;

  bin2sseg_fmt #(.ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .bin(bin), .blank_lz(blank_lz),
    .dp_en(dp_en), .dp_pos(dp_pos), .ready(ready), .done_tick(done_tick),
    .overflow(overflow), .led3(led3), .led2(led2), .led1(led1), .led0(led0)
  );

  always #5 clk = ~clk;

  // Start is presented in cycle 0; returns the cycle index in which done_tick
  // is seen (-1 if not within the budget). Inputs are scrambled after capture.
  task automatic run_conv(input logic [13:0] b, input logic bl, input logic de,
                          input logic [1:0] dpp, output int lat);
    @(negedge clk);
    bin = b; blank_lz = bl; dp_en = de; dp_pos = dpp; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; bin = ~b; blank_lz = ~bl; dp_en = ~de; dp_pos = ~dpp;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done_tick) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; bin = '0; blank_lz = 1'b0; dp_en = 1'b0; dp_pos = '0;
    repeat (2) @(negedge clk);
    total++; if ({led3, led2, led1, led0} !== 32'hFFFFFFFF) begin bad++;
      $display("FAIL reset_led got=%h exp=FFFFFFFF", {led3, led2, led1, led0}); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
    total++; if (done_tick !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_tick); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat;
    run_conv(14'd1234, 1'b0, 1'b0, 2'd0, lat);
    total++; if (lat !== 15) begin bad++; $display("FAIL basic_latency got=%0d exp=15", lat); end
    total++; if ({led3, led2, led1, led0} !== 32'hF9A4B099) begin bad++;
      $display("FAIL basic_led got=%h exp=F9A4B099", {led3, led2, led1, led0}); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL basic_ready_in_done got=%b exp=0", ready); end
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL basic_ready_cycle16 got=%b exp=1", ready); end
    total++; if (done_tick !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%b exp=0", done_tick); end
    repeat (3) @(negedge clk);
    total++; if ({led3, led2, led1, led0} !== 32'hF9A4B099) begin bad++;
      $display("FAIL basic_hold got=%h exp=F9A4B099", {led3, led2, led1, led0}); end
  endtask

  task automatic test_blank;
    int lat;
    run_conv(14'd7, 1'b1, 1'b0, 2'd0, lat);
    total++; if ({led3, led2, led1, led0} !== 32'hFFFFFFF8) begin bad++;
      $display("FAIL blank_7 got=%h exp=FFFFFFF8", {led3, led2, led1, led0}); end
    run_conv(14'd0, 1'b1, 1'b0, 2'd0, lat);
    total++; if ({led3, led2, led1, led0} !== 32'hFFFFFFC0) begin bad++;
      $display("FAIL blank_0 got=%h exp=FFFFFFC0", {led3, led2, led1, led0}); end
    run_conv(14'd305, 1'b1, 1'b0, 2'd0, lat);
    total++; if ({led3, led2, led1, led0} !== 32'hFFB0C092) begin bad++;
      $display("FAIL blank_305 got=%h exp=FFB0C092", {led3, led2, led1, led0}); end
  endtask

  task automatic test_dp;
    int lat;
    run_conv(14'd5, 1'b1, 1'b1, 2'd2, lat);
    total++; if ({led3, led2, led1, led0} !== 32'hFF40C092) begin bad++;
      $display("FAIL dp_005 got=%h exp=FF40C092", {led3, led2, led1, led0}); end
    run_conv(14'd1234, 1'b0, 1'b1, 2'd0, lat);
    total++; if ({led3, led2, led1, led0} !== 32'hF9A4B019) begin bad++;
      $display("FAIL dp_pos0 got=%h exp=F9A4B019", {led3, led2, led1, led0}); end
  endtask

  task automatic test_overflow;
    int lat;
    run_conv(14'd10000, 1'b1, 1'b1, 2'd1, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL ovf_latency got=%0d exp=1", lat); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    total++; if ({led3, led2, led1, led0} !== 32'hBFBFBFBF) begin bad++;
      $display("FAIL ovf_led got=%h exp=BFBFBFBF", {led3, led2, led1, led0}); end
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL ovf_ready got=%b exp=1", ready); end
    run_conv(14'd9999, 1'b0, 1'b0, 2'd0, lat);
    total++; if (lat !== 15) begin bad++; $display("FAIL max_latency got=%0d exp=15", lat); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL max_flag got=%b exp=0", overflow); end
    total++; if ({led3, led2, led1, led0} !== 32'h90909090) begin bad++;
      $display("FAIL max_led got=%h exp=90909090", {led3, led2, led1, led0}); end
  endtask

  task automatic test_back_to_back;
    int pulses = 0;
    @(negedge clk);
    bin = 14'd1234; blank_lz = 1'b0; dp_en = 1'b0; dp_pos = 2'd0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 5) begin bin = 14'd9999; blank_lz = 1'b1; start = 1'b1; end
      if (c == 6) start = 1'b0;
      if (done_tick) pulses++;
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL restart_pulses got=%0d exp=1", pulses); end
    total++; if ({led3, led2, led1, led0} !== 32'hF9A4B099) begin bad++;
      $display("FAIL restart_led got=%h exp=F9A4B099", {led3, led2, led1, led0}); end
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    int lat;
    @(negedge clk);
    bin = 14'd1234; blank_lz = 1'b0; dp_en = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if ({led3, led2, led1, led0} !== 32'hFFFFFFFF) begin bad++;
      $display("FAIL midreset_led got=%h exp=FFFFFFFF", {led3, led2, led1, led0}); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%b exp=1", ready); end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done_tick) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL midreset_pulses got=%0d exp=0", pulses); end
    run_conv(14'd42, 1'b1, 1'b0, 2'd0, lat);
    total++; if ({led3, led2, led1, led0} !== 32'hFFFF99A4) begin bad++;
      $display("FAIL after_reset_42 got=%h exp=FFFF99A4", {led3, led2, led1, led0}); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_blank;
    test_dp;
    test_overflow;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
